// File: rtl/mult_pkg.sv
// Shared sizing helpers for the pipelined Wallace-tree multiplier.
package mult_pkg;

    // Widest product the correction helper can describe.
    localparam int unsigned MAX_PROD_W = 128;

    // Rows entering the tree for a WIDTH x WIDTH multiply: one row per bit
    // of the (WIDTH+1)-bit extended multiplier plus the Baugh-Wooley
    // correction-constant row.
    function automatic int unsigned pp_rows(input int unsigned width);
        return width + 2;
    endfunction

    // Number of 3:2 compressor levels needed to bring 'rows' down to two.
    // Each level turns every complete group of three rows into two.
    function automatic int unsigned wallace_levels(input int unsigned rows);
        int unsigned r;
        int unsigned l;
        r = rows;
        l = 0;
        while (r > 2) begin
            r = r - (r / 3);
            l = l + 1;
        end
        return l;
    endfunction

    // Baugh-Wooley constant for an n=(width+1)-bit signed multiply is
    // 2^n + 2^(2n-1). The 2^(2n-1) term lies above the 2*width-bit product
    // and vanishes under truncation, leaving 2^(width+1).
    function automatic logic [MAX_PROD_W-1:0] bw_correction(input int unsigned width);
        return MAX_PROD_W'(1) << (width + 1);
    endfunction

endpackage

// File: rtl/wallace_reduce.sv
// Combinational Baugh-Wooley partial-product generation and Wallace
// reduction of a (W+1)x(W+1) signed multiply to sum/carry vectors.
module wallace_reduce
    import mult_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic signed [W:0]     a_i,
    input  logic signed [W:0]     b_i,
    output logic        [2*W-1:0] sum_o,
    output logic        [2*W-1:0] carry_o
);

    localparam int unsigned P      = 2 * W;
    localparam int unsigned ROWS   = pp_rows(W);
    localparam int unsigned LEVELS = wallace_levels(ROWS);

    logic [ROWS-1:0][P-1:0] pp;
    logic [ROWS-1:0][P-1:0] cur;
    logic [ROWS-1:0][P-1:0] nxt;
    logic [P-1:0]           x;
    logic [P-1:0]           y;
    logic [P-1:0]           z;
    logic [P-1:0]           maj;
    int unsigned            cnt;
    int unsigned            grp;

    // Partial-product rows: bits pairing exactly one sign bit are inverted,
    // and the last row carries the correction constant.
    always_comb begin
        pp = '0;
        for (int unsigned i = 0; i <= W; i++) begin
            for (int unsigned j = 0; j <= W; j++) begin
                if (i + j < P) begin
                    pp[i][i+j] = (a_i[j] & b_i[i]) ^ ((i == W) != (j == W));
                end
            end
        end
        pp[ROWS-1] = P'(bw_correction(W));
    end

    // Wallace levels: each complete triple of rows goes through a row of
    // full adders; leftover rows are packed down behind the new pairs so
    // the live rows always occupy indices 0..cnt-1.
    always_comb begin
        cur = pp;
        nxt = '0;
        cnt = ROWS;
        grp = 0;
        x   = '0;
        y   = '0;
        z   = '0;
        maj = '0;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            nxt = '0;
            grp = cnt / 3;
            for (int unsigned g = 0; g < ROWS / 3; g++) begin
                if (g < grp) begin
                    x   = cur[3*g];
                    y   = cur[3*g+1];
                    z   = cur[3*g+2];
                    maj = (x & y) | (x & z) | (y & z);
                    nxt[2*g]   = x ^ y ^ z;
                    nxt[2*g+1] = {maj[P-2:0], 1'b0};
                end
            end
            for (int unsigned k = 0; k < ROWS; k++) begin
                if (k >= 3 * grp && k < cnt) begin
                    nxt[k-grp] = cur[k];
                end
            end
            cur = nxt;
            cnt = cnt - grp;
        end
        sum_o   = cur[0];
        carry_o = cur[1];
    end

endmodule

// File: rtl/wallace_mult_pipe.sv
// Two-stage pipelined multiplier: S1 registers the compressed sum/carry,
// S2 registers the carry-propagate result. Valid/ready on both sides.
module wallace_mult_pipe
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 a_signed,
    input  logic                 b_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     out_tag
);

    logic signed [WIDTH:0]   a_ext;
    logic signed [WIDTH:0]   b_ext;
    logic [2*WIDTH-1:0]      s1_sum_d;
    logic [2*WIDTH-1:0]      s1_carry_d;
    logic [2*WIDTH-1:0]      s1_sum_q;
    logic [2*WIDTH-1:0]      s1_carry_q;
    logic [TAG_W-1:0]        s1_tag_q;
    logic                    s1_valid_q;
    logic [2*WIDTH-1:0]      product_d;
    logic [2*WIDTH-1:0]      product_q;
    logic [TAG_W-1:0]        out_tag_q;
    logic                    out_valid_q;
    logic                    s1_en;
    logic                    s2_en;
    logic                    accept;

    // Operand extension to WIDTH+1 bits according to the per-op signedness.
    always_comb begin
        a_ext = {a_signed & a[WIDTH-1], a};
        b_ext = {b_signed & b[WIDTH-1], b};
    end

    wallace_reduce #(
        .W (WIDTH)
    ) u_reduce (
        .a_i     (a_ext),
        .b_i     (b_ext),
        .sum_o   (s1_sum_d),
        .carry_o (s1_carry_d)
    );

    // Stall-on-full flow control: a stage advances when its successor can take data.
    always_comb begin
        s2_en     = !out_valid_q || out_ready;
        s1_en     = !s1_valid_q || s2_en;
        in_ready  = s1_en && rst_n;
        accept    = in_valid && in_ready;
        product_d = s1_sum_q + s1_carry_q;
    end

    // Pipeline registers; data registers load only when a valid entry moves in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_carry_q  <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            out_tag_q   <= '0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= accept;
            end
            if (accept) begin
                s1_sum_q   <= s1_sum_d;
                s1_carry_q <= s1_carry_d;
                s1_tag_q   <= in_tag;
            end
            if (s2_en) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    product_q <= product_d;
                    out_tag_q <= s1_tag_q;
                end
            end
        end
    end

    // Output port drive.
    always_comb begin
        out_valid = out_valid_q;
        product   = product_q;
        out_tag   = out_tag_q;
    end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
module tb_wallace_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WIDTH=16 instance (directed and random)
    logic        in_valid, in_ready, a_signed, b_signed, out_valid, out_ready;
    logic [15:0] a, b;
    logic [3:0]  in_tag, out_tag;
    logic [31:0] product;

    // WIDTH=8 instance (random)
    logic        in_valid_8, in_ready_8, a_signed_8, b_signed_8, out_valid_8, out_ready_8;
    logic [7:0]  a_8, b_8;
    logic [3:0]  in_tag_8, out_tag_8;
    logic [15:0] product_8;

    // WIDTH=23 instance (random)
    logic        in_valid_23, in_ready_23, a_signed_23, b_signed_23, out_valid_23, out_ready_23;
    logic [22:0] a_23, b_23;
    logic [3:0]  in_tag_23, out_tag_23;
    logic [45:0] product_23;

    int errors = 0;
    int checks = 0;

    logic [63:0] sb_p [3][$];
    logic [3:0]  sb_t [3][$];

    wallace_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .out_tag(out_tag)
    );

    wallace_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .a(a_8), .b(b_8), .a_signed(a_signed_8), .b_signed(b_signed_8), .in_tag(in_tag_8),
        .out_valid(out_valid_8), .out_ready(out_ready_8), .product(product_8), .out_tag(out_tag_8)
    );

    wallace_mult_pipe #(.WIDTH(23), .TAG_W(4)) dut23 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_23), .in_ready(in_ready_23),
        .a(a_23), .b(b_23), .a_signed(a_signed_23), .b_signed(b_signed_23), .in_tag(in_tag_23),
        .out_valid(out_valid_23), .out_ready(out_ready_23), .product(product_23), .out_tag(out_tag_23)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input bit v, input logic [15:0] av, input logic [15:0] bv,
                           input bit as, input bit bs, input logic [3:0] t);
        in_valid = v;
        a        = av;
        b        = bv;
        a_signed = as;
        b_signed = bs;
        in_tag   = t;
    endtask

    // Reference: native multiply of the sign/zero-extended operands.
    function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                            input int w, input bit xs, input bit ys);
        longint ex, ey;
        logic [63:0] p;
        ex = longint'(x);
        ey = longint'(y);
        if (xs && x[w-1]) ex = ex - (longint'(1) << w);
        if (ys && y[w-1]) ey = ey - (longint'(1) << w);
        p = 64'(ex * ey);
        return p & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic test_reset;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive16(1'b1, 16'h1234, 16'h5678, 1'b1, 1'b1, 4'h9);
        repeat (3) begin
            step();
            checks += 3;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
            if (product !== 32'h0) begin errors++; $display("FAIL reset product: got %h want 00000000", product); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL release out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_modes;
        logic [15:0] va [7];
        logic [15:0] vb [7];
        bit          sa [7];
        bit          sb [7];
        logic [31:0] ex [7];
        va = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF};
        vb = '{16'h0001, 16'h0001, 16'h0001, 16'h3000, 16'h3000, 16'h8000, 16'hFFFF};
        sa = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        sb = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ex = '{32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF, 32'hE8000000,
               32'h18000000, 32'h40000000, 32'hFFFE0001};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive16(1'b1, va[i], vb[i], sa[i], sb[i], 4'(i + 1));
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL mode%0d in_ready: got %b want 1", i, in_ready); end
            step();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL mode%0d early out_valid: got %b want 0", i, out_valid); end
            step();
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d out_valid: got %b want 1", i, out_valid); end
            if (product !== ex[i]) begin errors++; $display("FAIL mode%0d product: got %h want %h", i, product, ex[i]); end
            if (out_tag !== 4'(i + 1)) begin errors++; $display("FAIL mode%0d tag: got %h want %h", i, out_tag, 4'(i + 1)); end
            step();
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] va [8];
        logic [15:0] vb [8];
        bit          sg [8];
        logic [31:0] ex [8];
        va = '{16'h00AA, 16'h0003, 16'h0100, 16'h1234, 16'hFFFF, 16'h7FFF, 16'hFFFE, 16'h0000};
        vb = '{16'h0055, 16'h0003, 16'h0100, 16'h0010, 16'hFFFF, 16'h7FFF, 16'h0002, 16'hBEEF};
        sg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ex = '{32'h00003872, 32'h00000009, 32'h00010000, 32'h00012340,
               32'h00000001, 32'h3FFF0001, 32'hFFFFFFFC, 32'h00000000};
        out_ready = 1'b1;
        for (int e = 0; e < 10; e++) begin
            if (e < 8) drive16(1'b1, va[e], vb[e], sg[e], sg[e], 4'(e + 3));
            else in_valid = 1'b0;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL stream%0d in_ready: got %b want 1", e, in_ready); end
            step();
            if (e >= 1 && e <= 8) begin
                checks += 3;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL stream%0d out_valid: got %b want 1", e, out_valid); end
                if (product !== ex[e-1]) begin errors++; $display("FAIL stream%0d product: got %h want %h", e, product, ex[e-1]); end
                if (out_tag !== 4'(e + 2)) begin errors++; $display("FAIL stream%0d tag: got %h want %h", e, out_tag, 4'(e + 2)); end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL stream%0d idle out_valid: got %b want 0", e, out_valid); end
            end
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive16(1'b1, 16'h0002, 16'h0003, 1'b0, 1'b0, 4'hA);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp first in_ready: got %b want 1", in_ready); end
        step();
        drive16(1'b1, 16'h0010, 16'h0010, 1'b0, 1'b0, 4'hB);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp second in_ready: got %b want 1", in_ready); end
        step();
        drive16(1'b1, 16'h0007, 16'h0009, 1'b0, 1'b0, 4'hC);
        for (int s = 0; s < 3; s++) begin
            #1;
            checks += 4;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d in_ready: got %b want 0", s, in_ready); end
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d out_valid: got %b want 1", s, out_valid); end
            if (product !== 32'h00000006) begin errors++; $display("FAIL bp%0d held product: got %h want 00000006", s, product); end
            if (out_tag !== 4'hA) begin errors++; $display("FAIL bp%0d held tag: got %h want a", s, out_tag); end
            if (s < 2) step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        for (int s = 0; s < 2; s++) begin
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp shift%0d out_valid: got %b want 1", s, out_valid); end
            if (product !== 32'h00000100) begin errors++; $display("FAIL bp shift%0d product: got %h want 00000100", s, product); end
            if (out_tag !== 4'hB) begin errors++; $display("FAIL bp shift%0d tag: got %h want b", s, out_tag); end
            step();
        end
        out_ready = 1'b1;
        step();
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp last out_valid: got %b want 1", out_valid); end
        if (product !== 32'h0000003F) begin errors++; $display("FAIL bp last product: got %h want 0000003f", product); end
        if (out_tag !== 4'hC) begin errors++; $display("FAIL bp last tag: got %h want c", out_tag); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp drained out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_stall;
        out_ready = 1'b0;
        drive16(1'b1, 16'h0005, 16'h0005, 1'b0, 1'b0, 4'hD);
        step();
        drive16(1'b1, 16'h0006, 16'h0006, 1'b0, 1'b0, 4'hE);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rststall full out_valid: got %b want 1", out_valid); end
        rst_n = 1'b0;
        step();
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rststall out_valid: got %b want 0", out_valid); end
        if (product !== 32'h0) begin errors++; $display("FAIL rststall product: got %h want 00000000", product); end
        if (out_tag !== 4'h0) begin errors++; $display("FAIL rststall tag: got %h want 0", out_tag); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rststall in_ready: got %b want 0", in_ready); end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step();
            checks += 2;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rststall stale%0d out_valid: got %b want 0", s, out_valid); end
            if (in_ready !== 1'b1) begin errors++; $display("FAIL rststall after%0d in_ready: got %b want 1", s, in_ready); end
        end
    endtask

    task automatic test_random;
        localparam int N = 10000;
        int          wd [3];
        int unsigned acc [3];
        int unsigned ret [3];
        int unsigned occ [3];
        bit          cv [3];
        bit          cr [3];
        bit          cas [3];
        bit          cbs [3];
        logic [63:0] ca [3];
        logic [63:0] cb [3];
        logic [3:0]  ct [3];
        bit          ir, ov, exp_ir, done;
        logic [63:0] op, ep;
        logic [3:0]  ot, et;
        int          cyc;
        wd = '{8, 16, 23};
        for (int k = 0; k < 3; k++) begin
            acc[k] = 0; ret[k] = 0; occ[k] = 0;
        end
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 40000) begin
            for (int k = 0; k < 3; k++) begin
                cv[k]  = (acc[k] < N) && ($urandom_range(0, 99) < 70);
                cr[k]  = ($urandom_range(0, 99) < 75);
                cas[k] = 1'($urandom);
                cbs[k] = 1'($urandom);
                ca[k]  = {$urandom, $urandom} & ((64'd1 << wd[k]) - 64'd1);
                cb[k]  = {$urandom, $urandom} & ((64'd1 << wd[k]) - 64'd1);
                ct[k]  = 4'(acc[k]);
                case (k)
                    0: begin
                        in_valid_8 = cv[k]; a_8 = ca[k][7:0]; b_8 = cb[k][7:0];
                        a_signed_8 = cas[k]; b_signed_8 = cbs[k]; in_tag_8 = ct[k]; out_ready_8 = cr[k];
                    end
                    1: begin
                        in_valid = cv[k]; a = ca[k][15:0]; b = cb[k][15:0];
                        a_signed = cas[k]; b_signed = cbs[k]; in_tag = ct[k]; out_ready = cr[k];
                    end
                    default: begin
                        in_valid_23 = cv[k]; a_23 = ca[k][22:0]; b_23 = cb[k][22:0];
                        a_signed_23 = cas[k]; b_signed_23 = cbs[k]; in_tag_23 = ct[k]; out_ready_23 = cr[k];
                    end
                endcase
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                case (k)
                    0:       begin ir = in_ready_8;  ov = out_valid_8;  op = 64'(product_8);  ot = out_tag_8;  end
                    1:       begin ir = in_ready;    ov = out_valid;    op = 64'(product);    ot = out_tag;    end
                    default: begin ir = in_ready_23; ov = out_valid_23; op = 64'(product_23); ot = out_tag_23; end
                endcase
                exp_ir = (occ[k] < 2) || cr[k];
                checks++;
                if (ir !== exp_ir) begin
                    errors++;
                    $display("FAIL rand w%0d in_ready cyc %0d: got %b want %b", wd[k], cyc, ir, exp_ir);
                end
                if (ov === 1'b1 && cr[k]) begin
                    if (sb_p[k].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rand w%0d spurious result cyc %0d: got %h want none", wd[k], cyc, op);
                    end else begin
                        ep = sb_p[k].pop_front();
                        et = sb_t[k].pop_front();
                        checks += 2;
                        if (op !== ep) begin errors++; $display("FAIL rand w%0d product #%0d: got %h want %h", wd[k], ret[k], op, ep); end
                        if (ot !== et) begin errors++; $display("FAIL rand w%0d tag #%0d: got %h want %h", wd[k], ret[k], ot, et); end
                        ret[k]++;
                        occ[k]--;
                    end
                end
                if (cv[k] && ir === 1'b1) begin
                    sb_p[k].push_back(ref_mul(ca[k], cb[k], wd[k], cas[k], cbs[k]));
                    sb_t[k].push_back(ct[k]);
                    acc[k]++;
                    occ[k]++;
                end
            end
            step();
            cyc++;
            done = 1'b1;
            for (int k = 0; k < 3; k++) if (acc[k] != N || ret[k] != N) done = 1'b0;
        end
        in_valid = 1'b0; in_valid_8 = 1'b0; in_valid_23 = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rand timeout: got acc %0d/%0d/%0d ret %0d/%0d/%0d want %0d each",
                     acc[0], acc[1], acc[2], ret[0], ret[1], ret[2], N);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive16(1'b0, '0, '0, 1'b0, 1'b0, '0);
        out_ready   = 1'b1;
        in_valid_8  = 1'b0; a_8  = '0; b_8  = '0; a_signed_8  = 1'b0; b_signed_8  = 1'b0; in_tag_8  = '0; out_ready_8  = 1'b1;
        in_valid_23 = 1'b0; a_23 = '0; b_23 = '0; a_signed_23 = 1'b0; b_signed_23 = 1'b0; in_tag_23 = '0; out_ready_23 = 1'b1;
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_reset_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
